if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/if_stage_npc.sv | 33 +++
 rtl/if_stage.sv | 92 +++++++++
 tb/tb_if_stage.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg -- shared encodings for the fetch front end.
//   NOP          : canonical ADDI x0,x0,0 used to fill a flushed IF/ID.
//   NPC_*        : one-hot EX next-PC request encodings (000 = sequential).
//   RESET_PC_DEF : default fetch address after reset.
//   ifid_t       : IF/ID pipeline register contents.
package riscv_pkg;
  localparam logic [31:0] NOP          = 32'h0000_0013;
  localparam logic [2:0]  NPC_PLUS4    = 3'b000;
  localparam logic [2:0]  NPC_BRANCH   = 3'b001;
  localparam logic [2:0]  NPC_JUMP     = 3'b010;
  localparam logic [2:0]  NPC_JALR     = 3'b100;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;
endpackage

// File: rtl/if_stage_npc.sv
// npc -- combinational next-PC selection.
//   pc          : current PC
//   npc_op      : EX next-PC request (JALR > JAL > branch when several set)
//   ex_pc/ex_imm/ex_alu_out : EX operands for the redirect target
//   pc4         : pc + 4 (wraps mod 2^32)
//   next_pc     : word-aligned redirect target, or pc4 when sequential
//   redirect    : any request bit set
//   tgt_bit1    : computed target has bit1 set (raised as misalign next cycle)
module npc
  import riscv_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [2:0]  npc_op,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_alu_out,
  output logic [31:0] pc4,
  output logic [31:0] next_pc,
  output logic        redirect,
  output logic        tgt_bit1
);
  logic [31:0] target;

  always_comb begin
    pc4      = pc + 32'd4;
    redirect = |npc_op;
    // JALR uses rs1+imm with bit0 cleared; JAL and branch share pc-relative form.
    if ((npc_op & NPC_JALR) != 3'b000) target = {ex_alu_out[31:1], 1'b0};
    else                               target = ex_pc + ex_imm;
    tgt_bit1 = redirect & target[1];
    next_pc  = redirect ? {target[31:2], 2'b00} : pc4;
  end
endmodule

// File: rtl/if_stage.sv
// if_stage -- instruction fetch: PC register, IF/ID register, redirect/stall.
//   clk, rst        : clock, synchronous active-high reset
//   NPCOp           : EX next-PC request ([0] branch, [1] JAL, [2] JALR)
//   ex_pc, ex_imm, ex_alu_out : EX operands for redirect target
//   stall           : hold PC and IF/ID
//   imem_addr       : fetch address (= PC, combinational)
//   imem_rdata      : instruction word for imem_addr
//   id_pc, id_pc4, id_instr, id_valid : IF/ID contents
//   misalign        : one-cycle pulse after a redirect with target[1] set
// Optional: IF_STAGE_PERF_CNT_EN adds fetch_cnt / flush_cnt outputs.
// Priority each edge: rst > redirect > stall > sequential fetch.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  NPCOp,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_alu_out,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic        misalign
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt
`endif
);
  localparam ifid_t IFID_FLUSH = '{pc: 32'd0, pc4: 32'd0, instr: NOP, valid: 1'b0};

  logic [31:0] pc, pc4, next_pc;
  logic        redirect, tgt_bit1;
  ifid_t       ifid;

  npc u_npc (
    .pc        (pc),
    .npc_op    (NPCOp),
    .ex_pc     (ex_pc),
    .ex_imm    (ex_imm),
    .ex_alu_out(ex_alu_out),
    .pc4       (pc4),
    .next_pc   (next_pc),
    .redirect  (redirect),
    .tgt_bit1  (tgt_bit1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      ifid     <= IFID_FLUSH;
      misalign <= 1'b0;
    end else if (redirect) begin
      // Wrong-path fetch is discarded, so a concurrent stall is irrelevant.
      pc       <= next_pc;
      ifid     <= IFID_FLUSH;
      misalign <= tgt_bit1;
    end else if (stall) begin
      misalign <= 1'b0;
    end else begin
      pc       <= next_pc;
      ifid     <= '{pc: pc, pc4: pc4, instr: imem_rdata, valid: 1'b1};
      misalign <= 1'b0;
    end
  end

`ifdef IF_STAGE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else if (redirect) begin
      flush_cnt <= flush_cnt + 32'd1;
    end else if (!stall) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`endif

  assign imem_addr = pc;
  assign id_pc     = ifid.pc;
  assign id_pc4    = ifid.pc4;
  assign id_instr  = ifid.instr;
  assign id_valid  = ifid.valid;
endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  NPCOp;
  logic [31:0] ex_pc, ex_imm, ex_alu_out;
  logic        stall;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] id_pc, id_pc4, id_instr;
  logic        id_valid, misalign;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [31:0] fetch_cnt, flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // reference state
  logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_instr;
  logic        m_valid, m_mis;
  logic [31:0] m_fetch, m_flush;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .NPCOp(NPCOp), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_alu_out(ex_alu_out), .stall(stall), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .id_pc(id_pc), .id_pc4(id_pc4),
    .id_instr(id_instr), .id_valid(id_valid), .misalign(misalign)
`ifdef IF_STAGE_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'd0) return 32'h0050_0093;
    return (a * 32'd2654435761) ^ 32'h0000_0013;
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the reference model by one clock edge using the stated priorities.
  task automatic model(input logic r, input logic [2:0] op, input logic s,
                       input logic [31:0] epc, input logic [31:0] imm,
                       input logic [31:0] alu);
    logic [31:0] tgt;
    if (r) begin
      m_pc = 32'h0; m_id_pc = 0; m_id_pc4 = 0; m_id_instr = 32'h13;
      m_valid = 0; m_mis = 0; m_fetch = 0; m_flush = 0;
    end else if (op != 3'd0) begin
      if (op >= 3'd4) tgt = alu - (alu % 2);
      else            tgt = epc + imm;
      m_mis = (tgt % 4) >= 2;
      m_pc = tgt - (tgt % 4);
      m_id_pc = 0; m_id_pc4 = 0; m_id_instr = 32'h13; m_valid = 0;
      m_flush = m_flush + 1;
    end else if (s) begin
      m_mis = 0;
    end else begin
      m_id_pc = m_pc; m_id_pc4 = m_pc + 4; m_id_instr = mem(m_pc); m_valid = 1;
      m_pc = m_pc + 4; m_mis = 0; m_fetch = m_fetch + 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"},    imem_addr, m_pc);
    chk({tag, ".idpc"},  id_pc, m_id_pc);
    chk({tag, ".idpc4"}, id_pc4, m_id_pc4);
    chk({tag, ".instr"}, id_instr, m_id_instr);
    chk({tag, ".vld"},   {31'd0, id_valid}, {31'd0, m_valid});
    chk({tag, ".mis"},   {31'd0, misalign}, {31'd0, m_mis});
`ifdef IF_STAGE_PERF_CNT_EN
    chk({tag, ".fcnt"},  fetch_cnt, m_fetch);
    chk({tag, ".xcnt"},  flush_cnt, m_flush);
`endif
  endtask

  task automatic step(input string tag, input logic r, input logic [2:0] op,
                      input logic s, input logic [31:0] epc,
                      input logic [31:0] imm, input logic [31:0] alu);
    @(negedge clk);
    rst = r; NPCOp = op; stall = s; ex_pc = epc; ex_imm = imm; ex_alu_out = alu;
    model(r, op, s, epc, imm, alu);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1; NPCOp = 0; stall = 0; ex_pc = 0; ex_imm = 0; ex_alu_out = 0;
    m_pc = 0; m_id_pc = 0; m_id_pc4 = 0; m_id_instr = 0;
    m_valid = 0; m_mis = 0; m_fetch = 0; m_flush = 0;

    // reset for two cycles, then first fetches
    step("rst0", 1, 3'b000, 0, 0, 0, 0);
    step("rst1", 1, 3'b000, 0, 0, 0, 0);
    chk("rst.instr_nop", id_instr, 32'h0000_0013);
    chk("rst.addr0", imem_addr, 32'h0);
    step("fetch0", 0, 3'b000, 0, 0, 0, 0);
    chk("fetch0.instr", id_instr, 32'h0050_0093);
    chk("fetch0.addr", imem_addr, 32'h4);
    step("fetch1", 0, 3'b000, 0, 0, 0, 0);

    // move to 0x10, fetch once, then stall 3 cycles
    step("br10", 0, 3'b001, 0, 32'h10, 32'h0, 0);
    step("seq10", 0, 3'b000, 0, 0, 0, 0);
    step("seq14", 0, 3'b000, 0, 0, 0, 0);
    step("br10b", 0, 3'b001, 0, 32'h10, 32'h0, 0);
    step("seq10b", 0, 3'b000, 0, 0, 0, 0);
    step("br10c", 0, 3'b010, 0, 32'h8, 32'h8, 0);
    for (int i = 0; i < 3; i++) step("stall", 0, 3'b000, 1, 0, 0, 0);
    chk("stall.addr", imem_addr, 32'h10);
    step("release", 0, 3'b000, 0, 0, 0, 0);
    chk("release.addr", imem_addr, 32'h14);

    // branch backward with concurrent stall: flush wins
    step("brstall", 0, 3'b001, 1, 32'h20, 32'hFFFF_FFF0, 0);
    chk("brstall.addr", imem_addr, 32'h10);
    chk("brstall.vld", {31'd0, id_valid}, 32'd0);

    // all bits set -> JALR; then target with bit1 set
    step("jalr7", 0, 3'b111, 0, 32'h40, 32'h8, 32'h101);
    chk("jalr7.addr", imem_addr, 32'h100);
    step("jalr_mis", 0, 3'b100, 0, 0, 0, 32'h106);
    chk("jalr_mis.addr", imem_addr, 32'h104);
    chk("jalr_mis.mis", {31'd0, misalign}, 32'd1);
    step("after_mis", 0, 3'b000, 0, 0, 0, 0);
    chk("after_mis.mis", {31'd0, misalign}, 32'd0);

    // PC wrap at top of address space
    step("jal_top", 0, 3'b010, 0, 32'hFFFF_FFF0, 32'hC, 0);
    step("wrap", 0, 3'b000, 0, 0, 0, 0);
    chk("wrap.addr", imem_addr, 32'h0);
    chk("wrap.idpc4", id_pc4, 32'h0);

    // reset during redirect and during stall
    step("rst_redir", 1, 3'b010, 0, 32'h80, 32'h20, 0);
    step("seq_r", 0, 3'b000, 0, 0, 0, 0);
    step("rst_stall", 1, 3'b000, 1, 0, 0, 0);
    step("seq_r2", 0, 3'b000, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      step("rnd", ($urandom_range(0, 49) == 0), op, ($urandom_range(0, 3) == 0),
           $urandom, $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
